turn_fsm_n: RTL
===============

# turn_fsm_n

Parametrised turn controller for the N-player board game. It sequences setup, per-player attack turns, random fallback attacks and hit checking, and drives one-hot attack enables to the player input blocks. It also generates the per-turn timeout internally and skips eliminated players during rotation. It sits between the player input/attack datapaths, the random-attack generator and the board checker.

## Interface
- NUM_PLAYERS, 2: player count supported, 2..8; PW = $clog2(NUM_PLAYERS) is derived, not overridable.
- TURN_CYCLES, 1000: cycles a player may spend in ATTACK before random fallback, at least 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; leaves IDLE or OVER.
- num_active  in  PW+1  players in this game; sampled on start; clamped to 2..NUM_PLAYERS.
- first_player  in  PW  starting player; sampled on start; a value ≥ num_active becomes 0.
- select  in  1  setup confirmed.
- end_attack  in  NUM_PLAYERS  per-player attack-done pulse; only bit [current_player] is honoured.
- random_done  in  1  random attack finished.
- check_done  in  1  checker finished; gameover is valid with it.
- gameover  in  1  checker verdict: current player has won.
- eliminated  in  NUM_PLAYERS  level mask of players with no ships left.
- timeout_ext  in  1  external turn timeout; used only without TURN_TIMER_EN.
- current_player  out  PW  player whose turn it is.
- temp_state  out  4  state code.
- en_attack  out  NUM_PLAYERS  one-hot, bit [current_player] set in ATTACK.
- en_attack_random  out  1  high in RANDOM.
- en_check  out  1  high in CHECK.
- game_over  out  1  high in OVER.
- winner  out  PW  valid while game_over is high.
- turn_count  out  16  completed turns, saturating.

## Operation
- States and codes: IDLE=0, SETUP=1, ATTACK=2, RANDOM=3, CHECK=4, NEXT=5, OVER=6. Codes 7..15 are illegal and return to IDLE.
- IDLE: start → SETUP. Latch the clamped num_active and first_player; clear turn_count.
- SETUP: select → ATTACK with current_player = first_player; clear the timer.
- ATTACK: end_attack[current_player] → CHECK. Otherwise timeout → RANDOM. If both occur in the same cycle, end_attack wins.
- RANDOM: random_done → CHECK.
- CHECK: on check_done, gameover=1 → OVER with winner=current_player; otherwise → NEXT.
- NEXT: one cycle. Increment turn_count, saturating at 0xFFFF. Next player is the first index after current, modulo num_active, whose eliminated bit is clear.
  - If none exists, → OVER with winner=current_player.
  - Otherwise → ATTACK with the new player and the timer cleared.
- OVER: hold game_over and winner. start → SETUP and behaves exactly like start in IDLE.
- Outputs are Moore-decoded from registered state and current_player.
- end_attack bits of non-current players are ignored.
- eliminated is sampled only in NEXT.
- After rst, every output is 0: temp_state=0, current_player=0, en_attack=0, en_attack_random=0, en_check=0, game_over=0, winner=0, turn_count=0.

## Timing
- Every transition takes effect at the rising edge on which its condition is sampled; the new state is visible in the following cycle.
- start → SETUP: 1 cycle. select → en_attack asserted: 1 cycle.
- Internal timeout asserts when the ATTACK cycle count reaches TURN_CYCLES. With no end_attack, RANDOM is entered exactly TURN_CYCLES cycles after ATTACK entry.
- Each player turn costs CHECK (≥1 cycle) plus NEXT (1 cycle) before the next ATTACK.
- rst asserted mid-turn clears all state and outputs immediately (asynchronous), with no pending handshakes retained.
- The handshake inputs random_done and check_done are single-cycle pulses. Asserting one outside its state has no effect.

## Configuration
- TURN_TIMER_EN defined: internal counter of $clog2(TURN_CYCLES+1) bits generates the timeout, and timeout_ext is ignored.
- TURN_TIMER_EN undefined: no counter is built, timeout_ext is the timeout and is honoured only in ATTACK, and TURN_CYCLES is unused.

## Structure
- Shared package turn_pkg holds the state enum (4-bit, codes above), the turn_count width constant (16), and the NUM_PLAYERS limit (8).
- One sub-module, next_player_sel: combinational rotation scan taking current, num_active and eliminated, returning next index plus a none_left flag.

## Test plan
- NUM_PLAYERS=4, start with num_active=3, first_player=1, then select → en_attack=4'b0010; end_attack=4'b0010 → en_check; check_done with gameover=0 → current_player=2, turn_count=1.
- TURN_TIMER_EN, TURN_CYCLES=8, no end_attack → RANDOM exactly 8 cycles after ATTACK entry; random_done → CHECK.
- Rotation with eliminated=4'b0001, num_active=3, current=2 → next=1. With eliminated=4'b0110, current=0 → OVER, winner=0.
- end_attack and timeout in the same cycle → CHECK, not RANDOM. end_attack=4'b0100 while current=1 → ignored.
- gameover=1 with check_done, current=3 → game_over=1, winner=3. start → SETUP and turn_count=0.
- rst asserted in RANDOM → all outputs 0 immediately and temp_state=0. start=1 with num_active=9 on an 8-player build → clamped to 8; first_player=7 is accepted.

Source files
------------

// File: rtl/turn_pkg.sv
// Shared types and constants for the N-player turn controller.
package turn_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StSetup  = 4'd1,
        StAttack = 4'd2,
        StRandom = 4'd3,
        StCheck  = 4'd4,
        StNext   = 4'd5,
        StOver   = 4'd6
    } state_e;

    localparam int unsigned TURN_COUNT_W = 16;
    localparam int unsigned MAX_PLAYERS  = 8;

    function automatic logic [TURN_COUNT_W-1:0] sat_inc(input logic [TURN_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/next_player_sel.sv
// Combinational rotation scan: first non-eliminated player after i_current, modulo i_num_active.
module next_player_sel
    import turn_pkg::*;
#(
    parameter  int unsigned NUM_PLAYERS = 2,
    localparam int unsigned PW          = $clog2(NUM_PLAYERS)
) (
    input  logic [PW-1:0]          i_current,
    input  logic [PW:0]            i_num_active,
    input  logic [NUM_PLAYERS-1:0] i_eliminated,
    output logic [PW-1:0]          o_next,
    output logic                   o_none_left
);

    logic [PW+1:0] w_cand;

    // Scan offsets from largest to smallest so the nearest live player is the last write.
    always_comb begin
        o_next      = i_current;
        o_none_left = 1'b1;
        w_cand      = '0;
        for (int i = NUM_PLAYERS - 1; i >= 1; i--) begin
            w_cand = {2'b00, i_current} + (PW+2)'(i);
            if (w_cand >= {1'b0, i_num_active}) begin
                w_cand = w_cand - {1'b0, i_num_active};
            end
            if (((PW+2)'(i) < {1'b0, i_num_active}) && !i_eliminated[w_cand[PW-1:0]]) begin
                o_next      = w_cand[PW-1:0];
                o_none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/turn_fsm_n.sv
// Turn controller for the N-player board game: setup, attack turns, random fallback, checking.
// Optional macro TURN_TIMER_EN builds the internal per-turn timeout counter.
module turn_fsm_n
    import turn_pkg::*;
#(
    parameter  int unsigned NUM_PLAYERS = 2,
    parameter  int unsigned TURN_CYCLES = 1000,
    localparam int unsigned PW          = $clog2(NUM_PLAYERS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [PW:0]             i_num_active,
    input  logic [PW-1:0]           i_first_player,
    input  logic                    i_select,
    input  logic [NUM_PLAYERS-1:0]  i_end_attack,
    input  logic                    i_random_done,
    input  logic                    i_check_done,
    input  logic                    i_gameover,
    input  logic [NUM_PLAYERS-1:0]  i_eliminated,
    input  logic                    i_timeout_ext,
    output logic [PW-1:0]           o_current_player,
    output logic [3:0]              o_temp_state,
    output logic [NUM_PLAYERS-1:0]  o_en_attack,
    output logic                    o_en_attack_random,
    output logic                    o_en_check,
    output logic                    o_game_over,
    output logic [PW-1:0]           o_winner,
    output logic [TURN_COUNT_W-1:0] o_turn_count
);

    state_e                  r_state, w_state_next;
    logic [PW-1:0]           r_cur, w_cur_next;
    logic [PW:0]             r_num, w_num_next;
    logic [PW-1:0]           r_first, w_first_next;
    logic [PW-1:0]           r_winner, w_winner_next;
    logic [TURN_COUNT_W-1:0] r_turns, w_turns_next;

    logic [PW:0]             w_num_clamped;
    logic [PW-1:0]           w_first_clamped;
    logic [PW-1:0]           w_next;
    logic                    w_none_left;
    logic                    w_timeout;

    always_comb begin
        if (i_num_active < (PW+1)'(2)) begin
            w_num_clamped = (PW+1)'(2);
        end else if (i_num_active > (PW+1)'(NUM_PLAYERS)) begin
            w_num_clamped = (PW+1)'(NUM_PLAYERS);
        end else begin
            w_num_clamped = i_num_active;
        end
        w_first_clamped = ({1'b0, i_first_player} >= w_num_clamped) ? '0 : i_first_player;
    end

    next_player_sel #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_next_sel (
        .i_current   (r_cur),
        .i_num_active(r_num),
        .i_eliminated(i_eliminated),
        .o_next      (w_next),
        .o_none_left (w_none_left)
    );

`ifdef TURN_TIMER_EN
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

    logic [TW-1:0] r_timer, w_timer_next;
    logic          w_unused_ext;

    assign w_unused_ext = i_timeout_ext;
    // r_timer counts completed ATTACK cycles, so this fires on the TURN_CYCLES-th one.
    assign w_timeout    = (r_timer == TW'(TURN_CYCLES - 1));

    always_comb begin
        w_timer_next = '0;
        if ((r_state == StAttack) && (w_state_next == StAttack)) begin
            w_timer_next = r_timer + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_next;
        end
    end
`else
    logic w_unused_tc;

    assign w_unused_tc = (TURN_CYCLES != 0);
    assign w_timeout   = i_timeout_ext;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_cur_next    = r_cur;
        w_num_next    = r_num;
        w_first_next  = r_first;
        w_winner_next = r_winner;
        w_turns_next  = r_turns;
        case (r_state)
            StIdle, StOver: begin
                if (i_start) begin
                    w_state_next = StSetup;
                    w_num_next   = w_num_clamped;
                    w_first_next = w_first_clamped;
                    w_turns_next = '0;
                end
            end
            StSetup: begin
                if (i_select) begin
                    w_state_next = StAttack;
                    w_cur_next   = r_first;
                end
            end
            StAttack: begin
                if (i_end_attack[r_cur]) begin
                    w_state_next = StCheck;
                end else if (w_timeout) begin
                    w_state_next = StRandom;
                end
            end
            StRandom: begin
                if (i_random_done) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                if (i_check_done) begin
                    if (i_gameover) begin
                        w_state_next  = StOver;
                        w_winner_next = r_cur;
                    end else begin
                        w_state_next = StNext;
                    end
                end
            end
            StNext: begin
                w_turns_next = sat_inc(r_turns);
                if (w_none_left) begin
                    w_state_next  = StOver;
                    w_winner_next = r_cur;
                end else begin
                    w_state_next = StAttack;
                    w_cur_next   = w_next;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_cur    <= '0;
            r_num    <= '0;
            r_first  <= '0;
            r_winner <= '0;
            r_turns  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cur    <= w_cur_next;
            r_num    <= w_num_next;
            r_first  <= w_first_next;
            r_winner <= w_winner_next;
            r_turns  <= w_turns_next;
        end
    end

    assign o_current_player   = r_cur;
    assign o_temp_state       = r_state;
    assign o_en_attack        = (r_state == StAttack) ? (NUM_PLAYERS'(1) << r_cur) : '0;
    assign o_en_attack_random = (r_state == StRandom);
    assign o_en_check         = (r_state == StCheck);
    assign o_game_over        = (r_state == StOver);
    assign o_winner           = o_game_over ? r_winner : '0;
    assign o_turn_count       = r_turns;

endmodule
